lsu: RTL and testbench

Load/store unit sitting directly downstream of the main decoder, between the datapath and the data memory port. It consumes the decoder's memory-write flag, its load indication (`resultsrc == 01`) and the funct3 width code, together with the ALU address and rs2 data. It runs a request/grant/response handshake to data memory and stalls the single-cycle core until the access completes. It also generates byte enables, replicates store data, and sign- or zero-extends load data.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_if.sv | 30 +++
 rtl/lsu_align.sv | 81 ++++++++
 rtl/lsu.sv | 142 ++++++++++++++
 tb/tb_lsu.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit and the decoder.
package lsu_pkg;

  // Width codes carried in funct3 of load/store instructions.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One byte enable per byte lane of the 32-bit data bus.
  localparam int BE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Data memory port: request/grant for the command, rvalid for read data.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The LSU issues commands and consumes grant/read data.
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // The memory accepts commands and returns grant/read data.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: byte enables, store replication,
// request legality/alignment check and load lane extraction/extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [2:0]            f3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata_rep,
  output logic                  err,
  input  logic [2:0]            rsp_f3,
  input  logic [1:0]            rsp_offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  logic [DATA_WIDTH-1:0] lane_s;

  // Byte enables and store data replicated onto every lane of the access size.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (f3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Reject conflicting flags, unknown width codes and misaligned halfword/word accesses.
  always_comb begin
    err = 1'b0;
    if (memread && memwrite) begin
      err = 1'b1;
    end else if (memread) begin
      case (f3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = offset[0];
        F3_LW:         err = (offset != 2'b00);
        default:       err = 1'b1;
      endcase
    end else if (memwrite) begin
      case (f3)
        F3_LB:   err = 1'b0;
        F3_LH:   err = offset[0];
        F3_LW:   err = (offset != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      err = 1'b0;
    end
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  always_comb begin
    lane_s    = rdata >> {rsp_offset, 3'b000};
    rdata_ext = lane_s;
    case (rsp_f3)
      F3_LB:   rdata_ext = {{(DATA_WIDTH-8){lane_s[7]}}, lane_s[7:0]};
      F3_LH:   rdata_ext = {{(DATA_WIDTH-16){lane_s[15]}}, lane_s[15:0]};
      F3_LBU:  rdata_ext = {{(DATA_WIDTH-8){1'b0}}, lane_s[7:0]};
      F3_LHU:  rdata_ext = {{(DATA_WIDTH-16){1'b0}}, lane_s[15:0]};
      default: rdata_ext = lane_s;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one memory access per load/store instruction and
// stalls the single-cycle core until that access has completed.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_memread,
  input  logic                  i_memwrite,
  input  logic [2:0]            i_f3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_done,
  output logic                  o_err,
  lsu_if.master                 mem
);

  lsu_state_t            state_r;
  logic [2:0]            f3_r;
  logic [1:0]            offset_r;
  logic                  done_r;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [BE_WIDTH-1:0]   mem_be_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;

  logic                  op_s;
  logic [BE_WIDTH-1:0]   be_s;
  logic [DATA_WIDTH-1:0] wdata_rep_s;
  logic                  req_err_s;
  logic [DATA_WIDTH-1:0] rdata_ext_s;

  assign op_s = i_memread | i_memwrite;

  // Request side uses the live decoder inputs; response side uses the latched access.
  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .memread    (i_memread),
    .memwrite   (i_memwrite),
    .f3         (i_f3),
    .offset     (i_addr[1:0]),
    .wdata      (i_wdata),
    .be         (be_s),
    .wdata_rep  (wdata_rep_s),
    .err        (req_err_s),
    .rsp_f3     (f3_r),
    .rsp_offset (offset_r),
    .rdata      (mem.mem_rdata),
    .rdata_ext  (rdata_ext_s)
  );

  // The core advances only in DONE; any other cycle with a memory op freezes it.
  assign o_stall = op_s & (state_r != DONE);

  // Access sequencer with registered memory command, completion pulse and load result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      f3_r        <= 3'b000;
      offset_r    <= 2'b00;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_be_r    <= {BE_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (op_s && req_err_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            err_r   <= 1'b1;
            rdata_r <= {DATA_WIDTH{1'b0}};
          end else if (op_s) begin
            state_r     <= REQ;
            mem_req_r   <= 1'b1;
            mem_we_r    <= i_memwrite;
            mem_addr_r  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_r    <= be_s;
            mem_wdata_r <= wdata_rep_s;
            f3_r        <= i_f3;
            offset_r    <= i_addr[1:0];
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem_req_r <= 1'b0;
            if (mem_we_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= WAIT;
            end
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            rdata_r <= rdata_ext_s;
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_done        = done_r;
  assign o_err         = err_r;
  assign o_rdata       = rdata_r;
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_be    = mem_be_r;
  assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vectors plus randomized accesses,
// compared against a size/offset arithmetic model of the access rules.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread;
  logic        memwrite;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = 32'h0;

  lsu_if bus ();

  lsu dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_memread  (memread),
    .i_memwrite (memwrite),
    .i_f3       (f3),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_stall    (stall),
    .o_rdata    (rdata),
    .o_done     (done),
    .o_err      (err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit m_err(input logic mr, input logic mw, input logic [2:0] f, input logic [31:0] a);
    if (mr && mw) return 1'b1;
    if (mr) begin
      if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b1;
    end else begin
      if (f > 3'b010) return 1'b1;
    end
    return (a % size_of(f)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    int v;
    v = ((1 << size_of(f)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
    if (size_of(f) == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (size_of(f) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
    longint lane;
    longint v;
    int     bits;
    if (size_of(f) == 4) return r;
    bits = 8 * size_of(f);
    lane = longint'(r) >> (8 * (a % 4));
    v    = lane & ((64'd1 << bits) - 64'd1);
    if (!f[2] && v >= (64'd1 << (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // One complete access: drive it, play memory with the given delays, check everything.
  task automatic run_access(input string tag, input logic mr, input logic mw,
                            input logic [2:0] f, input logic [31:0] a, input logic [31:0] w,
                            input logic [31:0] r, input int gd, input int rd, input bit stray);
    bit e;
    int stalls = 0;
    int reqc = 0;
    int waitc = 0;
    int exp_stalls;
    bit granted = 1'b0;
    bit seen_req = 1'b0;
    bit got_done = 1'b0;
    e = m_err(mr, mw, f, a);
    exp_stalls = e ? 1 : (mw ? 2 + gd : 2 + gd + rd);
    memread = mr; memwrite = mw; f3 = f; addr = a; wdata = w;
    bus.mem_rdata = r; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (stall) stalls++;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (bus.mem_req) begin
        seen_req = 1'b1;
        reqc++;
        check({tag, "_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
        check({tag, "_be"}, {28'h0, bus.mem_be}, {28'h0, m_be(f, a)});
        check({tag, "_we"}, {31'h0, bus.mem_we}, {31'h0, mw});
        if (mw) check({tag, "_wdata"}, bus.mem_wdata, m_wdata(f, w));
        if (reqc == gd + 1) begin
          bus.mem_gnt = 1'b1;
          granted = 1'b1;
        end else if (stray) begin
          bus.mem_rvalid = 1'b1;
        end
      end else if (granted) begin
        waitc++;
        if (waitc == rd) bus.mem_rvalid = 1'b1;
      end else if (stray) begin
        bus.mem_gnt = 1'b1;
      end
      @(posedge clk);
    end
    check({tag, "_done"}, {31'h0, got_done}, 32'h1);
    if (got_done) begin
      if (e) last_rdata = 32'h0;
      else if (mr) last_rdata = m_load(f, a, r);
      check({tag, "_err"}, {31'h0, err}, {31'h0, e});
      check({tag, "_stall_at_done"}, {31'h0, stall}, 32'h0);
      check({tag, "_stall_cycles"}, stalls, exp_stalls);
      check({tag, "_req_issued"}, {31'h0, seen_req}, {31'h0, !e});
      check({tag, "_rdata"}, rdata, last_rdata);
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    step();
    check({tag, "_done_pulse"}, {30'h0, done, err}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; memread = 1'b1; memwrite = 1'b0; f3 = F3_LW; addr = 32'h40; wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

    // Reset held with a load pending: everything quiet except stall.
    repeat (3) step();
    check("rst_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_done_err", {30'h0, done, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_cmd", bus.mem_addr | bus.mem_wdata | {28'h0, bus.mem_be} | {31'h0, bus.mem_we}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b1;
    step();
    check("rst_release_req", {31'h0, bus.mem_req}, 32'h1);
    // Reset while in REQ drops the request on the next edge.
    rst_n = 1'b0; memread = 1'b0;
    step();
    check("rst_in_req", {31'h0, bus.mem_req}, 32'h0);
    rst_n = 1'b1;
    step();

    // Directed vectors.
    run_access("sb", 1'b0, 1'b1, F3_LB, 32'h103, 32'h0000_00A5, 32'h0, 0, 1, 1'b0);
    run_access("lh", 1'b1, 1'b0, F3_LH, 32'h202, 32'h0, 32'h8001_1234, 0, 1, 1'b0);
    check("lh_value", rdata, 32'hFFFF_8001);
    run_access("lhu", 1'b1, 1'b0, F3_LHU, 32'h202, 32'h0, 32'h8001_1234, 0, 1, 1'b0);
    check("lhu_value", rdata, 32'h0000_8001);
    run_access("lb", 1'b1, 1'b0, F3_LB, 32'h201, 32'h0, 32'h0000_7F00, 0, 1, 1'b0);
    check("lb_value", rdata, 32'h0000_007F);
    run_access("sw_hold", 1'b0, 1'b1, F3_LW, 32'h80, 32'h1234_5678, 32'h0, 1, 1, 1'b0);
    check("store_keeps_rdata", rdata, 32'h0000_007F);
    run_access("lw_mis", 1'b1, 1'b0, F3_LW, 32'h006, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0);
    check("lw_mis_value", rdata, 32'h0);
    run_access("lw_wait", 1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b1);
    run_access("sh", 1'b0, 1'b1, F3_LH, 32'h42, 32'hABCD_9876, 32'h0, 2, 1, 1'b1);
    run_access("both", 1'b1, 1'b1, F3_LW, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0);
    run_access("sbu_bad", 1'b0, 1'b1, F3_LBU, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0);

    // Randomized accesses, issued back to back.
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic        mr;
      logic        mw;
      logic [2:0]  fr;
      logic [31:0] ar;
      kind = int'($urandom_range(0, 9));
      mr = (kind <= 4) || (kind == 9);
      mw = (kind >= 5);
      if ($urandom_range(0, 3) == 0) fr = 3'($urandom_range(0, 7));
      else if (mr) fr = 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 2));
      else fr = 3'($urandom_range(0, 2));
      ar = $urandom & 32'h0000_0FFF;
      run_access("rand", mr, mw, fr, ar, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end
    memread = 1'b0; memwrite = 1'b0;
    step();

    // Reset while waiting for read data; a late rvalid must not complete anything.
    memread = 1'b1; f3 = F3_LW; addr = 32'h500;
    step();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("mid_wait_req", {31'h0, bus.mem_req}, 32'h0);
    rst_n = 1'b0;
    step();
    check("mid_rst_req", {31'h0, bus.mem_req}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    rst_n = 1'b1; memread = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      step();
      check("late_rvalid_done", {30'h0, done, err}, 32'h0);
    end
    bus.mem_rvalid = 1'b0;
    check("late_rvalid_rdata", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
